wfunc_coef_loader: RTL and testbench



---
 rtl/wfunc_pkg.sv | 26 ++
 rtl/wfunc_coef_loader_if.sv | 25 ++
 rtl/wfunc_coef_loader_apb_xfer.sv | 46 ++++
 rtl/wfunc_coef_loader.sv | 173 +++++++++++++++++
 tb/tb_wfunc_coef_loader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wfunc_pkg.sv
// rtl/wfunc_pkg.sv - shared state enum, control words and address helper for window_func loading
package wfunc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLD_SETUP,
        ST_HOLD_ACCESS,
        ST_WAIT_COEF,
        ST_WR_SETUP,
        ST_WR_ACCESS,
        ST_RB_SETUP,
        ST_RB_ACCESS,
        ST_RUN_SETUP,
        ST_RUN_ACCESS,
        ST_DRAIN
    } wfunc_ldr_state_t;

    localparam logic [31:0] WFUNC_CTRL_HOLD = 32'h0000_0000;
    localparam logic [31:0] WFUNC_CTRL_RUN  = 32'h0000_0001;

    // Control register sits at the top half of the APB window, above all coefficients.
    function automatic int unsigned wfunc_ctrl_addr(input int unsigned aw);
        return 32'd1 << (aw - 1);
    endfunction

endpackage

// File: rtl/wfunc_coef_loader_if.sv
// rtl/wfunc_coef_loader_if.sv - coefficient stream and APB master bundle of the loader
interface wfunc_coef_loader_if #(
    parameter int APB_AW = 16
);
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [31:0]       s_tdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_AW-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;

    modport master (
        input  s_tvalid, s_tlast, s_tdata, prdata,
        output s_tready, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output s_tvalid, s_tlast, s_tdata, prdata,
        input  s_tready, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/wfunc_coef_loader_apb_xfer.sv
// rtl/wfunc_coef_loader_apb_xfer.sv - two-phase APB master, setup then access, no wait states
module apb_xfer #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          ack,
    output logic [31:0]   rdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [31:0]   pwdata,
    input  logic [31:0]   prdata
);

    // A request in the access cycle chains straight into the next setup cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (req) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= wr;
            paddr   <= addr;
            pwdata  <= wdata;
        end else if (psel && !penable) begin
            penable <= 1'b1;
        end else begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    assign ack   = psel & penable;
    assign rdata = prdata;

endmodule

// File: rtl/wfunc_coef_loader.sv
// rtl/wfunc_coef_loader.sv - streams FFT_SIZE coefficients into window_func over APB; WFUNC_LOADER_READBACK_EN adds verify reads
module wfunc_coef_loader
    import wfunc_pkg::*;
#(
    parameter int                FFT_SIZE  = 8192,
    parameter int                APB_AW    = $clog2(FFT_SIZE - 1) + 3,
    parameter logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(wfunc_ctrl_addr(APB_AW)),
    parameter int                CW        = $clog2(FFT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    wfunc_coef_loader_if.master   bus
);

    wfunc_ldr_state_t  state;
    logic [CW-1:0]     cnt;
    logic              last_q;
    logic              s_tready_q;
    logic              xfer_req;
    logic              xfer_wr;
    logic              xfer_ack;
    logic [APB_AW-1:0] xfer_addr;
    logic [APB_AW-1:0] coef_addr;
    logic [31:0]       xfer_wdata;
    logic [31:0]       xfer_rdata;
    logic              cnt_max;
    logic              phase_end;
    logic              rb_bad;

    assign coef_addr = APB_AW'({cnt, 2'b00});
    assign cnt_max   = (cnt == CW'(FFT_SIZE - 1));

`ifdef WFUNC_LOADER_READBACK_EN
    logic [31:0] coef_q;
    assign phase_end = (state == ST_RB_ACCESS) && xfer_ack;
    assign rb_bad    = (state == ST_RB_ACCESS) && (xfer_rdata != coef_q);
`else
    assign phase_end = (state == ST_WR_ACCESS) && xfer_ack;
    assign rb_bad    = 1'b0;
`endif

    // Requests are issued one cycle ahead so the bus setup phase lines up with the *_SETUP state.
    always_comb begin
        xfer_req   = 1'b0;
        xfer_wr    = 1'b1;
        xfer_addr  = CTRL_ADDR;
        xfer_wdata = WFUNC_CTRL_HOLD;
        case (state)
            ST_IDLE: xfer_req = start;
            ST_WAIT_COEF: begin
                xfer_req   = bus.s_tvalid;
                xfer_addr  = coef_addr;
                xfer_wdata = bus.s_tdata;
            end
`ifdef WFUNC_LOADER_READBACK_EN
            ST_WR_ACCESS: begin
                xfer_req   = 1'b1;
                xfer_wr    = 1'b0;
                xfer_addr  = coef_addr;
                xfer_wdata = coef_q;
            end
`endif
            default: ;
        endcase
        if (phase_end && last_q && cnt_max && !rb_bad) begin
            xfer_req   = 1'b1;
            xfer_wdata = WFUNC_CTRL_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_q     <= 1'b0;
            s_tready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef WFUNC_LOADER_READBACK_EN
            coef_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    err   <= 1'b0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= ST_HOLD_SETUP;
                end
                ST_HOLD_SETUP:  state <= ST_HOLD_ACCESS;
                ST_HOLD_ACCESS: begin
                    state      <= ST_WAIT_COEF;
                    s_tready_q <= 1'b1;
                end
                ST_WAIT_COEF: if (bus.s_tvalid) begin
`ifdef WFUNC_LOADER_READBACK_EN
                    coef_q     <= bus.s_tdata;
`endif
                    last_q     <= bus.s_tlast;
                    s_tready_q <= 1'b0;
                    state      <= ST_WR_SETUP;
                end
                ST_WR_SETUP: state <= ST_WR_ACCESS;
`ifdef WFUNC_LOADER_READBACK_EN
                ST_WR_ACCESS: state <= ST_RB_SETUP;
                ST_RB_SETUP:  state <= ST_RB_ACCESS;
                ST_RB_ACCESS: ;
`else
                ST_WR_ACCESS: ;
`endif
                ST_RUN_SETUP:  state <= ST_RUN_ACCESS;
                ST_RUN_ACCESS: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                ST_DRAIN: if (bus.s_tvalid && bus.s_tlast) begin
                    state      <= ST_IDLE;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    s_tready_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (phase_end) begin
                if (rb_bad || (last_q && !cnt_max)) begin
                    err   <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end else if (last_q) begin
                    state <= ST_RUN_SETUP;
                end else if (cnt_max) begin
                    // Missing tlast: swallow the rest of the frame so the stream realigns.
                    err        <= 1'b1;
                    state      <= ST_DRAIN;
                    s_tready_q <= 1'b1;
                end else begin
                    cnt        <= cnt + 1'b1;
                    state      <= ST_WAIT_COEF;
                    s_tready_q <= 1'b1;
                end
            end
        end
    end

    assign bus.s_tready = s_tready_q;

    apb_xfer #(.AW(APB_AW)) u_apb_xfer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (xfer_req),
        .wr      (xfer_wr),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .ack     (xfer_ack),
        .rdata   (xfer_rdata),
        .psel    (bus.psel),
        .penable (bus.penable),
        .pwrite  (bus.pwrite),
        .paddr   (bus.paddr),
        .pwdata  (bus.pwdata),
        .prdata  (bus.prdata)
    );

endmodule

// File: tb/tb_wfunc_coef_loader.sv
// tb/tb_wfunc_coef_loader.sv - directed/random loads of a 16-entry window checked against a transaction model
module tb_wfunc_coef_loader;

    localparam int N  = 16;
    localparam int AW = 7;
    localparam logic [AW-1:0] CTRL = 7'h40;
`ifdef WFUNC_LOADER_READBACK_EN
    localparam bit RB  = 1'b1;
    localparam int PER = 5;
`else
    localparam bit RB  = 1'b0;
    localparam int PER = 3;
`endif

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } xact_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, err;

    wfunc_coef_loader_if #(.APB_AW(AW)) bus ();

    wfunc_coef_loader #(.FFT_SIZE(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          proto_err = 0;
    xact_t       log_q[$];
    xact_t       exp_q[$];
    logic [31:0] beat_data [32];
    int          last_idx;
    logic [31:0] last_wdata = 32'h0;
    bit          corrupt_on = 1'b0;
    bit          load_done = 1'b0;
    bit          abort_drv = 1'b0;
    logic        prev_setup = 1'b0;
    logic [39:0] prev_x = '0;

    // Slave model: a read returns the word just written, optionally with bit 3 flipped on coefficient 2.
    assign bus.prdata = last_wdata ^ ((corrupt_on && bus.paddr == 7'd8) ? 32'h8 : 32'h0);

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.psel && bus.penable) begin
                log_q.push_back(xact_t'({bus.pwrite, bus.paddr, bus.pwdata}));
                if (bus.pwrite) last_wdata <= bus.pwdata;
            end
            proto_err <= proto_err
                + int'(bus.psel && bus.penable &&
                       !(prev_setup && prev_x == {bus.pwrite, bus.paddr, bus.pwdata}))
                + int'(bus.penable && !bus.psel)
                + int'(bus.s_tready && bus.psel);
            prev_setup <= bus.psel && !bus.penable;
            prev_x     <= {bus.pwrite, bus.paddr, bus.pwdata};
        end else begin
            prev_setup <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected APB traffic derived from where the first tlast falls and which readback is corrupted.
    task automatic build_expect(input int first_last, input int bad_idx, output bit exp_err);
        int top;
        exp_q.delete();
        exp_err = 1'b0;
        exp_q.push_back(xact_t'({1'b1, CTRL, 32'h0}));
        top = (first_last < N - 1) ? first_last : N - 1;
        for (int k = 0; k <= top; k++) begin
            exp_q.push_back(xact_t'({1'b1, AW'(4 * k), beat_data[k]}));
            if (RB) exp_q.push_back(xact_t'({1'b0, AW'(4 * k), beat_data[k]}));
            if (k == bad_idx) begin
                exp_err = 1'b1;
                return;
            end
        end
        if (first_last == N - 1) exp_q.push_back(xact_t'({1'b1, CTRL, 32'h1}));
        else exp_err = 1'b1;
    endtask

    task automatic compare_log(input string tag, input bit prefix_only);
        if (!prefix_only) check({tag, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            xact_t o, e;
            o = log_q[i];
            e = exp_q[i];
            if (!e.wr) begin
                o.data = '0;
                e.data = '0;
            end
            check($sformatf("%s_xact%0d", tag, i), 64'(o), 64'(e));
        end
    endtask

    function automatic int count_writes();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr != CTRL) n++;
        return n;
    endfunction

    task automatic drive_stream(input int nbeats, input bit toggle, output int accepted);
        int cyc = 0;
        bit phase = 1'b0;
        bit hs;
        accepted = 0;
        while (accepted < nbeats && !load_done && !abort_drv && cyc < 2000) begin
            bus.s_tdata  = beat_data[accepted];
            bus.s_tlast  = (accepted == last_idx);
            bus.s_tvalid = toggle ? phase : 1'b1;
            @(negedge clk);
            hs = bus.s_tvalid && bus.s_tready;
            @(posedge clk);
            #1;
            if (hs) accepted++;
            phase = !phase;
            cyc++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_load(input string tag, input int nbeats, input bit toggle,
                            output int cycles, output int accepted);
        bit busy1;
        log_q.delete();
        load_done = 1'b0;
        abort_drv = 1'b0;
        pulse_start();
        fork
            drive_stream(nbeats, toggle, accepted);
            begin
                cycles = 0;
                busy1  = 1'b0;
                while (!load_done && cycles < 3000) begin
                    @(negedge clk);
                    cycles++;
                    if (cycles == 1) busy1 = busy;
                    if (done) load_done = 1'b1;
                end
            end
        join
        cycles = cycles - 1;
        check({tag, "_busy_rise"}, 64'(busy1), 64'd1);
        check({tag, "_done_seen"}, 64'(load_done), 64'd1);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_tready_idle"}, 64'(bus.s_tready), 64'd0);
    endtask

    initial begin
        int  cyc, acc, base_cyc, guard;
        bit  e_err;

        rst_n        = 1'b0;
        start        = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.s_tdata  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({busy, done, err, bus.s_tready, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}),
              64'd0);
        rst_n = 1'b1;

        // Nominal load with the reference ramp data.
        for (int k = 0; k < 32; k++) beat_data[k] = 32'h0001_0000 + k;
        last_idx = 15;
        run_load("nominal", 16, 1'b0, cyc, acc);
        build_expect(15, -1, e_err);
        compare_log("nominal", 1'b0);
        check("nominal_err", 64'(err), 64'(e_err));
        check("nominal_cycles", 64'(cyc), 64'(2 + PER * N + 2));
        check("nominal_accepted", 64'(acc), 64'd16);
        base_cyc = cyc;

        // Early tlast on beat 5.
        for (int k = 0; k < 32; k++) beat_data[k] = $urandom;
        last_idx = 5;
        run_load("early", 6, 1'b0, cyc, acc);
        build_expect(5, -1, e_err);
        compare_log("early", 1'b0);
        check("early_err", 64'(err), 64'(e_err));

        // Missing tlast: 20 beats, last on 19, four drained.
        for (int k = 0; k < 32; k++) beat_data[k] = $urandom;
        last_idx = 19;
        run_load("drain", 20, 1'b0, cyc, acc);
        build_expect(19, -1, e_err);
        compare_log("drain", 1'b0);
        check("drain_err", 64'(err), 64'(e_err));
        check("drain_accepted", 64'(acc), 64'd20);

        // Toggling valid: same traffic as nominal, longer run.
        for (int k = 0; k < 32; k++) beat_data[k] = 32'h0001_0000 + k;
        last_idx = 15;
        run_load("toggle", 16, 1'b1, cyc, acc);
        build_expect(15, -1, e_err);
        compare_log("toggle", 1'b0);
        check("toggle_err", 64'(err), 64'(e_err));
        check("toggle_slower", 64'(cyc > base_cyc), 64'd1);

        // Ignored start re-pulse, then reset while coefficient 7 is on the bus.
        for (int k = 0; k < 32; k++) beat_data[k] = $urandom;
        last_idx  = 15;
        log_q.delete();
        load_done = 1'b0;
        abort_drv = 1'b0;
        pulse_start();
        fork
            drive_stream(16, 1'b0, acc);
            begin
                guard = 0;
                while (count_writes() < 3 && guard < 500) begin
                    @(negedge clk);
                    guard++;
                end
                pulse_start();
                while (!(bus.psel && !bus.penable && bus.pwrite && bus.paddr == 7'd28) && guard < 500) begin
                    @(negedge clk);
                    guard++;
                end
                check("rst_reached_coef7", 64'(guard < 500), 64'd1);
                #1 rst_n = 1'b0;
                #1;
                check("rst_outputs",
                      64'({busy, done, err, bus.s_tready, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}),
                      64'd0);
                abort_drv = 1'b1;
            end
        join
        build_expect(15, -1, e_err);
        check("rst_prefix_len", 64'(log_q.size()), 64'(1 + 7 * (RB ? 2 : 1)));
        compare_log("rst_prefix", 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Clean load after reset.
        for (int k = 0; k < 32; k++) beat_data[k] = $urandom;
        last_idx = 15;
        run_load("reload", 16, 1'b0, cyc, acc);
        build_expect(15, -1, e_err);
        compare_log("reload", 1'b0);
        check("reload_err", 64'(err), 64'(e_err));
        check("reload_cycles", 64'(cyc), 64'(2 + PER * N + 2));

`ifdef WFUNC_LOADER_READBACK_EN
        // Corrupted readback of coefficient 2.
        for (int k = 0; k < 32; k++) beat_data[k] = $urandom;
        last_idx   = 15;
        corrupt_on = 1'b1;
        run_load("rbbad", 16, 1'b0, cyc, acc);
        corrupt_on = 1'b0;
        build_expect(15, 2, e_err);
        compare_log("rbbad", 1'b0);
        check("rbbad_err", 64'(err), 64'(e_err));
`endif

        check("protocol", 64'(proto_err), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
